// File: rtl/std_fifo_datapath.sv
// Storage and head-of-queue stage for std_fifo. It follows the controller's
// write/read strobes and pointers exactly and keeps no occupancy state.
module std_fifo_datapath #(
  parameter type TYPE              = logic,
  parameter int  DEPTH             = 8,
  parameter bit  DATA_FF_OUT       = 1'b1,
  parameter int  RAM_WORDS         = DATA_FF_OUT ? DEPTH - 1 : DEPTH,
  parameter int  RAM_POINTER_WIDTH = (RAM_WORDS >= 2) ? $clog2(RAM_WORDS) : 1,
  parameter bit  RESET_RAM         = 1'b0,
  parameter TYPE INITIAL_VALUE     = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_write_to_ff,
  input  logic                         i_write_to_ram,
  input  logic [RAM_POINTER_WIDTH-1:0] i_write_pointer,
  input  TYPE                          i_data,
  input  logic                         i_read_from_ram,
  input  logic [RAM_POINTER_WIDTH-1:0] i_read_pointer,
  output TYPE                          o_data
);

  TYPE w_ram_rd;

  // ---------------------------------------------------------------------------
  // RAM word array
  // ---------------------------------------------------------------------------
  generate
    if (RAM_WORDS >= 2) begin : g_ram
      TYPE r_ram [RAM_WORDS];

      if (RESET_RAM) begin : g_rst
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            for (int i = 0; i < RAM_WORDS; i++) r_ram[i] <= INITIAL_VALUE;
          end else if (i_write_to_ram) begin
            r_ram[i_write_pointer] <= i_data;
          end
        end
      end else begin : g_nrst
        always_ff @(posedge i_clk) begin
          if (i_write_to_ram) r_ram[i_write_pointer] <= i_data;
        end
      end

      // Asynchronous read sees pre-edge contents, giving read-before-write.
      assign w_ram_rd = r_ram[i_read_pointer];

      a_wr_ptr_range: assert property (@(posedge i_clk) disable iff (i_rst)
        i_write_to_ram |-> (int'(i_write_pointer) < RAM_WORDS));
      a_rd_ptr_range: assert property (@(posedge i_clk) disable iff (i_rst)
        i_read_from_ram |-> (int'(i_read_pointer) < RAM_WORDS));
    end else if (RAM_WORDS == 1) begin : g_ram1
      TYPE  r_ram;
      logic w_unused;

      if (RESET_RAM) begin : g_rst
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst)               r_ram <= INITIAL_VALUE;
          else if (i_write_to_ram) r_ram <= i_data;
        end
      end else begin : g_nrst
        always_ff @(posedge i_clk) begin
          if (i_write_to_ram) r_ram <= i_data;
        end
      end

      assign w_ram_rd = r_ram;
      assign w_unused = ^{i_write_pointer, i_read_pointer};
    end else begin : g_noram
      logic w_unused;

      // Only the output flop exists; RAM strobes must never be raised.
      assign w_ram_rd = INITIAL_VALUE;
      assign w_unused = ^{i_write_pointer, i_read_pointer, i_write_to_ram};

      a_no_ram_strobe: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_write_to_ram || i_read_from_ram));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Head-of-queue output
  // ---------------------------------------------------------------------------
  generate
    if (DATA_FF_OUT) begin : g_ff_out
      TYPE r_head;

      // A direct push beats a refill; both together is a controller bug.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                r_head <= INITIAL_VALUE;
        else if (i_write_to_ff)   r_head <= i_data;
        else if (i_read_from_ram) r_head <= w_ram_rd;
      end

      assign o_data = r_head;

      a_ff_vs_refill: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_write_to_ff && i_read_from_ram));
    end else begin : g_comb_out
      logic w_unused;

      assign o_data   = w_ram_rd;
      assign w_unused = ^{i_write_to_ff, i_read_from_ram};

      a_no_ff_write: assert property (@(posedge i_clk) disable iff (i_rst)
        !i_write_to_ff);
    end
  endgenerate

endmodule

// File: tb/tb_std_fifo_datapath.sv
// Directed bench for std_fifo_datapath in registered-head, combinational-head
// and single-entry configurations, checked against an expected-value queue.
module tb_std_fifo_datapath;

  typedef logic [7:0] byte_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Registered head, DEPTH=4 (3 RAM words, 2-bit pointers)
  logic       f_wff, f_wram, f_rram;
  logic [1:0] f_wp, f_rp;
  byte_t      f_d, f_q;

  // Combinational head, DEPTH=4, RAM reset (4 RAM words, 2-bit pointers)
  logic       c_wff, c_wram, c_rram;
  logic [1:0] c_wp, c_rp;
  byte_t      c_d, c_q;

  // Single entry, flop only
  logic       s_wff, s_wram, s_rram;
  logic [0:0] s_wp, s_rp;
  byte_t      s_d, s_q;

  std_fifo_datapath #(.TYPE(byte_t), .DEPTH(4), .DATA_FF_OUT(1'b1)) u_ff (
    .i_clk(clk), .i_rst(rst), .i_write_to_ff(f_wff), .i_write_to_ram(f_wram),
    .i_write_pointer(f_wp), .i_data(f_d), .i_read_from_ram(f_rram),
    .i_read_pointer(f_rp), .o_data(f_q));

  std_fifo_datapath #(.TYPE(byte_t), .DEPTH(4), .DATA_FF_OUT(1'b0),
                      .RESET_RAM(1'b1)) u_comb (
    .i_clk(clk), .i_rst(rst), .i_write_to_ff(c_wff), .i_write_to_ram(c_wram),
    .i_write_pointer(c_wp), .i_data(c_d), .i_read_from_ram(c_rram),
    .i_read_pointer(c_rp), .o_data(c_q));

  std_fifo_datapath #(.TYPE(byte_t), .DEPTH(1), .DATA_FF_OUT(1'b1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_write_to_ff(s_wff), .i_write_to_ram(s_wram),
    .i_write_pointer(s_wp), .i_data(s_d), .i_read_from_ram(s_rram),
    .i_read_pointer(s_rp), .o_data(s_q));

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_val(input byte_t v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input byte_t obs);
    byte_t exp;
    exp = exp_q.pop_front();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers: strobes are applied away from the edge, held across one rising
  // edge, then dropped 1 time unit later.
  // ---------------------------------------------------------------------------
  task automatic step_ff(input logic wff, input logic wram, input logic [1:0] wp,
                         input byte_t d, input logic rram, input logic [1:0] rp);
    f_wff = wff; f_wram = wram; f_wp = wp; f_d = d; f_rram = rram; f_rp = rp;
    @(posedge clk); #1;
    f_wff = 1'b0; f_wram = 1'b0; f_rram = 1'b0;
  endtask

  task automatic step_d1(input logic wff, input byte_t d);
    s_wff = wff; s_d = d;
    @(posedge clk); #1;
    s_wff = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    f_wff = 0; f_wram = 0; f_rram = 0; f_wp = 0; f_rp = 0; f_d = 0;
    c_wff = 0; c_wram = 0; c_rram = 0; c_wp = 0; c_rp = 0; c_d = 0;
    s_wff = 0; s_wram = 0; s_rram = 0; s_wp = 0; s_rp = 0; s_d = 0;

    // Reset values before any clock edge
    #2;
    expect_val(8'h00); check("ff_reset", f_q);
    expect_val(8'h00); check("comb_reset", c_q);
    expect_val(8'h00); check("d1_reset", s_q);

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Push into empty FIFO, visible the cycle after
    step_ff(1, 0, 2'd0, 8'hA1, 0, 2'd0);
    expect_val(8'hA1); check("ff_push_a1", f_q);

    // Asynchronous reset mid-cycle clears the head without a clock edge
    #2 rst = 1'b1;
    #1;
    expect_val(8'h00); check("ff_async_reset", f_q);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fill: head via flop, then three RAM words
    step_ff(1, 0, 2'd0, 8'h11, 0, 2'd0);
    expect_val(8'h11); check("fill_head", f_q);
    step_ff(0, 1, 2'd0, 8'h22, 0, 2'd0);
    expect_val(8'h11); check("fill_ram0_head_held", f_q);
    step_ff(0, 1, 2'd1, 8'h33, 0, 2'd0);
    expect_val(8'h11); check("fill_ram1_head_held", f_q);
    step_ff(0, 1, 2'd2, 8'h44, 0, 2'd0);
    expect_val(8'h11); check("fill_ram2_head_held", f_q);

    // Drain the RAM in order
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd0);
    expect_val(8'h22); check("pop_ptr0", f_q);
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd1);
    expect_val(8'h33); check("pop_ptr1", f_q);
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd2);
    expect_val(8'h44); check("pop_ptr2", f_q);

    // Full-RAM collision: refill gets the old word, new word is stored
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd0);
    expect_val(8'h22); check("pre_collision_head", f_q);
    step_ff(0, 1, 2'd0, 8'h55, 1, 2'd0);
    expect_val(8'h22); check("collision_old_word", f_q);
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd0);
    expect_val(8'h55); check("collision_new_word", f_q);
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd1);
    expect_val(8'h33); check("ram1_intact", f_q);

    // Pop of last entry with a coincident push goes straight to the flop
    step_ff(1, 0, 2'd0, 8'h77, 0, 2'd2);
    expect_val(8'h77); check("push_pop_last", f_q);
    step_ff(0, 0, 2'd0, 8'h00, 1, 2'd2);
    expect_val(8'h44); check("ram2_untouched", f_q);
    step_ff(0, 0, 2'd0, 8'hEE, 0, 2'd0);
    expect_val(8'h44); check("idle_hold", f_q);

    // Combinational head: write at edge N is visible right after edge N
    c_wram = 1'b1; c_wp = 2'd3; c_d = 8'h9C; c_rp = 2'd3;
    #1;
    expect_val(8'h00); check("comb_pre_edge", c_q);
    @(posedge clk); #1;
    c_wram = 1'b0;
    expect_val(8'h9C); check("comb_write_visible", c_q);

    c_wram = 1'b1; c_wp = 2'd1; c_d = 8'h5A;
    @(posedge clk); #1;
    c_wram = 1'b0;
    expect_val(8'h9C); check("comb_other_addr", c_q);
    c_rp = 2'd1;
    #1;
    expect_val(8'h5A); check("comb_ptr_move", c_q);

    // Reset clears every RAM word when RESET_RAM=1
    rst = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) begin
      c_rp = p[1:0];
      #1;
      expect_val(8'h00); check($sformatf("comb_reset_word%0d", p), c_q);
    end
    expect_val(8'h00); check("ff_reset_again", f_q);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single-entry FIFO: flop only
    step_d1(1, 8'h3C);
    expect_val(8'h3C); check("d1_push", s_q);
    step_d1(0, 8'hFF);
    expect_val(8'h3C); check("d1_hold", s_q);
    step_d1(1, 8'hC3);
    expect_val(8'hC3); check("d1_push_pop", s_q);

    // ---------------------------------------------------------------------------
    // Report
    // ---------------------------------------------------------------------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
